// File: rtl/ad_dac_framer_pkg.sv
// rtl/ad_dac_framer_pkg.sv - shared encodings for the AD9739 framer
package ad_dac_framer_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_RAMP   = 2'd2,
    MODE_CHECK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_FILL    = 2'd0,
    SEL_STREAM  = 2'd1,
    SEL_PATTERN = 2'd2
  } sel_e;

  localparam int CNT_WIDTH = 16;

endpackage

// File: rtl/ad_dac_pattern_gen.sv
// rtl/ad_dac_pattern_gen.sv - ramp and checkerboard beat source
// Used only when AD_DAC_FRAMER_PATTERN_EN is defined.
module ad_dac_pattern_gen #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    advance,
  input  logic                    sel_board,
  output logic [8*DATA_WIDTH-1:0] data
);

  localparam logic [DATA_WIDTH-1:0] BOARD_EVEN = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] BOARD_ODD  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [DATA_WIDTH-1:0] base;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      base <= '0;
    end else if (advance) begin
      base <= base + DATA_WIDTH'(8);
    end
  end

  always_comb begin
    data = '0;
    for (int k = 0; k < 8; k++) begin
      if (sel_board) begin
        data[k*DATA_WIDTH +: DATA_WIDTH] = (k % 2 == 0) ? BOARD_EVEN : BOARD_ODD;
      end else begin
        data[k*DATA_WIDTH +: DATA_WIDTH] = base + DATA_WIDTH'(k);
      end
    end
  end

endmodule

// File: rtl/ad_dac_framer.sv
// rtl/ad_dac_framer.sv - AD9739 div_clk framer: FSM, handshake, two-stage pipeline, formatting
// Ramp/checkerboard generators are compiled in when AD_DAC_FRAMER_PATTERN_EN is defined.
module ad_dac_framer
  import ad_dac_framer_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter bit OFFSET_BINARY = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [1:0]              mode,
  input  logic [8*DATA_WIDTH-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [DATA_WIDTH-1:0]   data_s0,
  output logic [DATA_WIDTH-1:0]   data_s1,
  output logic [DATA_WIDTH-1:0]   data_s2,
  output logic [DATA_WIDTH-1:0]   data_s3,
  output logic [DATA_WIDTH-1:0]   data_s4,
  output logic [DATA_WIDTH-1:0]   data_s5,
  output logic [DATA_WIDTH-1:0]   data_s6,
  output logic [DATA_WIDTH-1:0]   data_s7,
  output logic                    running,
  output logic                    underflow,
  output logic [CNT_WIDTH-1:0]    underflow_cnt
);

  // XOR mask: flips the MSB for offset binary, and is also the formatted fill word.
  localparam logic [DATA_WIDTH-1:0] FMT_ZERO =
    OFFSET_BINARY ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {DATA_WIDTH{1'b0}};

  state_e state, next_state;
  mode_e  eff_mode;

  sel_e                    sel_d, sel_q;
  logic                    uf_d, uf_q, uf_out;
  logic [8*DATA_WIDTH-1:0] pay_d, pay_q;
  logic [7:0][DATA_WIDTH-1:0] fmt_d, out_q;
  logic [CNT_WIDTH-1:0]    cnt_q;
  logic                    running_q;

  always_comb begin
`ifdef AD_DAC_FRAMER_PATTERN_EN
    eff_mode = mode_e'(mode);
`else
    eff_mode = (mode == 2'd0) ? MODE_STREAM : MODE_ZERO;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: next_state = ST_ARM;
        ST_ARM: begin
          if (eff_mode != MODE_STREAM || s_valid) next_state = ST_RUN;
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  // enable gates s_ready so a beat offered while disabling is never handshaken.
  always_comb begin
    s_ready = enable && (state != ST_IDLE) && (eff_mode == MODE_STREAM);
    sel_d   = SEL_FILL;
    uf_d    = 1'b0;
    if (s_ready) begin
      if (s_valid) begin
        sel_d = SEL_STREAM;
      end else if (state == ST_RUN) begin
        uf_d = 1'b1;
      end
    end else if (enable && state == ST_RUN &&
                 (eff_mode == MODE_RAMP || eff_mode == MODE_CHECK)) begin
      sel_d = SEL_PATTERN;
    end
  end

`ifdef AD_DAC_FRAMER_PATTERN_EN
  logic [8*DATA_WIDTH-1:0] pat_data;

  ad_dac_pattern_gen #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pattern_gen (
    .clk      (clk),
    .rst      (rst),
    .clear    (state != ST_RUN),
    .advance  (enable && state == ST_RUN && eff_mode == MODE_RAMP),
    .sel_board(eff_mode == MODE_CHECK),
    .data     (pat_data)
  );

  always_comb begin
    pay_d = (sel_d == SEL_PATTERN) ? pat_data : s_data;
  end
`else
  always_comb begin
    pay_d = s_data;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= SEL_FILL;
      pay_q <= '0;
      uf_q  <= 1'b0;
    end else begin
      sel_q <= sel_d;
      pay_q <= pay_d;
      uf_q  <= uf_d;
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      fmt_d[k] = (sel_q == SEL_FILL) ? FMT_ZERO
                                     : (pay_q[k*DATA_WIDTH +: DATA_WIDTH] ^ FMT_ZERO);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= {8{FMT_ZERO}};
      uf_out <= 1'b0;
    end else begin
      out_q  <= fmt_d;
      uf_out <= uf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      running_q <= 1'b0;
    end else begin
      running_q <= (next_state == ST_RUN);
      if (state == ST_IDLE && next_state != ST_IDLE) begin
        cnt_q <= '0;
      end else if (uf_d && cnt_q != {CNT_WIDTH{1'b1}}) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign data_s0       = out_q[0];
  assign data_s1       = out_q[1];
  assign data_s2       = out_q[2];
  assign data_s3       = out_q[3];
  assign data_s4       = out_q[4];
  assign data_s5       = out_q[5];
  assign data_s6       = out_q[6];
  assign data_s7       = out_q[7];
  assign running       = running_q;
  assign underflow     = uf_out;
  assign underflow_cnt = cnt_q;

endmodule

// File: tb/tb_ad_dac_framer.sv
// tb/tb_ad_dac_framer.sv - directed bench: two's complement and offset-binary framers side by side
module tb_ad_dac_framer;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [1:0]   mode;
  logic [127:0] s_data;
  logic         s_valid;

  logic        a_ready, a_running, a_uf;
  logic [15:0] a_cnt;
  logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7;
  logic        b_ready, b_running, b_uf;
  logic [15:0] b_cnt;
  logic [15:0] b0, b1, b2, b3, b4, b5, b6, b7;

  int n_tests = 0;
  int n_fail  = 0;

  ad_dac_framer #(.DATA_WIDTH(16), .OFFSET_BINARY(1'b0)) u_tc (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .s_data(s_data), .s_valid(s_valid), .s_ready(a_ready),
    .data_s0(a0), .data_s1(a1), .data_s2(a2), .data_s3(a3),
    .data_s4(a4), .data_s5(a5), .data_s6(a6), .data_s7(a7),
    .running(a_running), .underflow(a_uf), .underflow_cnt(a_cnt)
  );

  ad_dac_framer #(.DATA_WIDTH(16), .OFFSET_BINARY(1'b1)) u_ob (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .s_data(s_data), .s_valid(s_valid), .s_ready(b_ready),
    .data_s0(b0), .data_s1(b1), .data_s2(b2), .data_s3(b3),
    .data_s4(b4), .data_s5(b5), .data_s6(b6), .data_s7(b7),
    .running(b_running), .underflow(b_uf), .underflow_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  wire [127:0] a_out = {a7, a6, a5, a4, a3, a2, a1, a0};
  wire [127:0] b_out = {b7, b6, b5, b4, b3, b2, b1, b0};

  localparam logic [127:0] ZERO_TC   = '0;
  localparam logic [127:0] ZERO_OB   = {8{16'h8000}};
  localparam logic [127:0] BOARD_TC  = {4{16'h8000, 16'h7fff}};
  localparam logic [127:0] BOARD_OB  = {4{16'h0000, 16'hffff}};
  localparam logic [127:0] MIX_BEAT  = {{7{16'h1234}}, 16'hffff};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] ramp(input int start);
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(start + k);
    return v;
  endfunction

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0; s_valid = 1'b0; s_data = '0;
    tick();
    tick();
    check("rst_data_tc", a_out, ZERO_TC);
    check("rst_data_ob", b_out, ZERO_OB);
    check("rst_ready", {b_ready, a_ready}, 2'b00);
    check("rst_running", {b_running, a_running}, 2'b00);
    check("rst_underflow", {b_uf, a_uf}, 2'b00);
    check("rst_cnt", {b_cnt, a_cnt}, 32'd0);

    rst = 1'b0; enable = 1'b1;
    tick();
    check("arm_ready", a_ready, 1'b1);
    check("arm_running", a_running, 1'b0);
    s_valid = 1'b1; s_data = ramp(0);
    tick();
    check("run_running", a_running, 1'b1);
    s_data = ramp(8);
    tick();
    check("beat0", a_out, ramp(0));
    check("beat0_uf", a_uf, 1'b0);
    s_valid = 1'b0;
    tick();
    check("beat1", a_out, ramp(8));
    check("beat1_uf", a_uf, 1'b0);
    tick();
    check("fill0", a_out, ZERO_TC);
    check("fill0_uf", a_uf, 1'b1);
    tick();
    check("fill1", a_out, ZERO_TC);
    check("fill1_uf", a_uf, 1'b1);
    s_valid = 1'b1; s_data = MIX_BEAT;
    tick();
    check("fill2", a_out, ZERO_TC);
    check("fill2_uf", a_uf, 1'b1);
    check("uf_cnt3", a_cnt, 16'd3);
    s_valid = 1'b0; enable = 1'b0;
    tick();
    check("mix_tc", a_out, MIX_BEAT);
    check("mix_ob", b_out, MIX_BEAT ^ ZERO_OB);
    check("mix_uf", a_uf, 1'b0);
    check("disable_cnt", a_cnt, 16'd3);
    check("disable_ready", a_ready, 1'b0);
    check("disable_running", a_running, 1'b0);

    enable = 1'b1; mode = 2'd2;
    tick();
    check("cnt_clear", a_cnt, 16'd0);
    check("pat_arm_ready", a_ready, 1'b0);
    tick();
    tick();
    tick();
`ifdef AD_DAC_FRAMER_PATTERN_EN
    check("ramp0", a_out, ramp(0));
    tick();
    check("ramp1", a_out, ramp(8));
    repeat (8190) tick();
    check("ramp_last", a_out, ramp(65528));
    tick();
    check("ramp_wrap", a_out, ramp(0));
    check("ramp_wrap_ob", b_out, ramp(0) ^ ZERO_OB);
`else
    check("nopat_ramp", a_out, ZERO_TC);
    check("nopat_ready", a_ready, 1'b0);
    tick();
    check("nopat_ramp_ob", b_out, ZERO_OB);
`endif

    mode = 2'd3;
    tick();
    tick();
`ifdef AD_DAC_FRAMER_PATTERN_EN
    check("board_tc", a_out, BOARD_TC);
    check("board_ob", b_out, BOARD_OB);
`else
    check("nopat_board", a_out, ZERO_TC);
    check("nopat_board_ob", b_out, ZERO_OB);
`endif
    check("board_running", a_running, 1'b1);

    mode = 2'd0; s_valid = 1'b1; s_data = ramp(100);
    tick();
    s_valid = 1'b0;
    tick();
    check("mode_switch", a_out, ramp(100));
    check("mode_switch_cnt", a_cnt, 16'd1);

    rst = 1'b1; s_valid = 1'b1; s_data = ramp(200);
    tick();
    check("midrst_tc", a_out, ZERO_TC);
    check("midrst_ob", b_out, ZERO_OB);
    check("midrst_ready", a_ready, 1'b0);
    check("midrst_cnt", a_cnt, 16'd0);
    check("midrst_uf", a_uf, 1'b0);

    rst = 1'b0; s_valid = 1'b0;
    tick();
    tick();
    tick();
    check("arm_wait_cnt", a_cnt, 16'd0);
    check("arm_wait_uf", a_uf, 1'b0);
    s_valid = 1'b1; s_data = ramp(300);
    tick();
    s_valid = 1'b0;
    repeat (70000) tick();
    check("sat_cnt", {b_cnt, a_cnt}, {16'hffff, 16'hffff});
    check("sat_uf", {b_uf, a_uf}, 2'b11);
    check("sat_ready", {b_ready, a_ready}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
